pcounter_mc: RTL and testbench

Multi-channel programmable counter and successor to the single-channel `pcounter`. It holds `NUM_CH` independent counters of width `CNT_W`, each with its own load, limit, direction and one-shot/wrap mode. The block is programmed through the same `cfg_*` register interface the pcounter bench already drives, now with read-back. It sits behind the config bus and exports its counts, sticky done flags, terminal-count pulses and an aggregate interrupt.

---
 rtl/pcounter_mc_pkg.sv | 30 +++
 rtl/pcounter_mc_ch.sv | 102 ++++++++++
 rtl/pcounter_mc.sv | 79 +++++++
 tb/tb_pcounter_mc.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pcounter_mc_pkg.sv
// Shared register map, CTRL bit layout and types for the multi-channel
// programmable counter.
package pcounter_mc_pkg;

  localparam int REG_CTRL  = 0;
  localparam int REG_LOAD  = 1;
  localparam int REG_LIMIT = 2;
  localparam int REG_COUNT = 3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_DIR     = 1;
  localparam int CTRL_ONESHOT = 2;
  localparam int CTRL_DONE    = 3;
  localparam int CTRL_LOAD    = 4;
  localparam int CTRL_W       = 5;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  // Field order puts en in bit 0 so {done, ctrl_t} lines up with CTRL.
  typedef struct packed {
    logic oneshot;
    dir_e dir;
    logic en;
  } ctrl_t;

  function automatic logic [CTRL_W-1:0] ctrl_pack(input ctrl_t c, input logic done);
    return {1'b0, done, c};
  endfunction

endpackage

// File: rtl/pcounter_mc_ch.sv
// One counter channel: CTRL/LOAD/LIMIT/COUNT registers plus the
// write-versus-count priority logic.
module pcounter_ch
  import pcounter_mc_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_i,
  input  logic [1:0]       reg_i,
  input  logic [CNT_W-1:0] wdata_i,
  output logic [CNT_W-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             done_o,
  output logic             tc_o
);

  ctrl_t            ctrl_q, ctrl_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CTRL_W-1:0] wctrl, ctrl_rd;
  logic [CNT_W-1:0]  ctrl_rd_w;
  logic wr_ctrl, wr_load, wr_limit, wr_count;

  assign wr_ctrl  = wr_i && (reg_i == 2'(REG_CTRL));
  assign wr_load  = wr_i && (reg_i == 2'(REG_LOAD));
  assign wr_limit = wr_i && (reg_i == 2'(REG_LIMIT));
  assign wr_count = wr_i && (reg_i == 2'(REG_COUNT));

  // Narrow counters cannot carry every CTRL bit; missing bits act as 0.
  generate
    if (CNT_W >= CTRL_W) begin : g_wide
      assign wctrl     = wdata_i[CTRL_W-1:0];
      assign ctrl_rd_w = CNT_W'(ctrl_rd);
    end else begin : g_narrow
      assign wctrl     = CTRL_W'(wdata_i);
      assign ctrl_rd_w = ctrl_rd[CNT_W-1:0];
    end
  endgenerate

  assign ctrl_rd = ctrl_pack(ctrl_q, done_q);
  assign tc_o    = ctrl_q.en && (count_q == limit_q);

  always_comb begin
    ctrl_d  = ctrl_q;
    done_d  = done_q;
    load_d  = load_q;
    limit_d = limit_q;
    count_d = count_q;
    if (tc_o) begin
      done_d = 1'b1;
      if (ctrl_q.oneshot) ctrl_d.en = 1'b0;
      else                count_d   = load_q;
    end else if (ctrl_q.en) begin
      count_d = (ctrl_q.dir == DIR_DOWN) ? count_q - CNT_W'(1) : count_q + CNT_W'(1);
    end
    // Register writes are applied last so they override the counting update.
    if (wr_ctrl) begin
      ctrl_d.en      = wctrl[CTRL_EN];
      ctrl_d.dir     = dir_e'(wctrl[CTRL_DIR]);
      ctrl_d.oneshot = wctrl[CTRL_ONESHOT];
      if (wctrl[CTRL_DONE] && !tc_o) done_d = 1'b0;
      if (wctrl[CTRL_LOAD]) count_d = load_q;
    end
    if (wr_load)  load_d  = wdata_i;
    if (wr_limit) limit_d = wdata_i;
    if (wr_count) count_d = wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      done_q  <= 1'b0;
      load_q  <= '0;
      limit_q <= '0;
      count_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      done_q  <= done_d;
      load_q  <= load_d;
      limit_q <= limit_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (reg_i)
      2'(REG_CTRL):  rdata_o = ctrl_rd_w;
      2'(REG_LOAD):  rdata_o = load_q;
      2'(REG_LIMIT): rdata_o = limit_q;
      default:       rdata_o = count_q;
    endcase
  end

  assign count_o = count_q;
  assign done_o  = done_q;

endmodule

// File: rtl/pcounter_mc.sv
// Multi-channel programmable counter: config-bus decode, per-channel
// instances and the registered read-back path.
module pcounter_mc
  import pcounter_mc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 10,
  parameter int ADDR_W = (NUM_CH <= 2) ? 3 : $clog2(NUM_CH) + 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_enable,
  input  logic                    cfg_rd_wr,
  input  logic [ADDR_W-1:0]       cfg_addr,
  input  logic [CNT_W-1:0]        cfg_wdata,
  output logic [CNT_W-1:0]        cfg_rdata,
  output logic                    cfg_rvalid,
  output logic [NUM_CH*CNT_W-1:0] counter_o,
  output logic [NUM_CH-1:0]       done_o,
  output logic [NUM_CH-1:0]       tc_pulse_o,
  output logic                    irq_o
);

  localparam int CH_W = ADDR_W - 2;

  logic [CH_W-1:0] ch_sel;
  logic [1:0]      reg_sel;
  logic            wr, rd;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_arr, rd_arr;
  logic [NUM_CH-1:0]            done_arr, tc_arr;
  logic [CNT_W-1:0] rdata_d, rdata_q;
  logic             rvalid_q;

  assign ch_sel  = cfg_addr[ADDR_W-1:2];
  assign reg_sel = cfg_addr[1:0];
  assign wr      = cfg_enable && !cfg_rd_wr;
  assign rd      = cfg_enable && cfg_rd_wr;

  // Channel codes >= NUM_CH match no instance, so such writes fall away.
  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      pcounter_ch #(.CNT_W(CNT_W)) u_ch (
        .clk     (clk),
        .rst     (rst),
        .wr_i    (wr && (ch_sel == CH_W'(k))),
        .reg_i   (reg_sel),
        .wdata_i (cfg_wdata),
        .rdata_o (rd_arr[k]),
        .count_o (cnt_arr[k]),
        .done_o  (done_arr[k]),
        .tc_o    (tc_arr[k])
      );
    end
  endgenerate

  always_comb begin
    rdata_d = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (ch_sel == CH_W'(k)) rdata_d = rd_arr[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd;
      if (rd) rdata_q <= rdata_d;
    end
  end

  assign cfg_rdata  = rdata_q;
  assign cfg_rvalid = rvalid_q;
  assign counter_o  = cnt_arr;
  assign done_o     = done_arr;
  assign tc_pulse_o = tc_arr;
  assign irq_o      = |done_arr;

endmodule

// File: tb/tb_pcounter_mc.sv
// Bench for pcounter_mc: a 4-channel and a 3-channel instance, table-driven
// register accesses, scoreboarded read-back and hand sequences for counting.
module tb_pcounter_mc;

  localparam int CW = 10;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;

  logic          cfg_enable, cfg_rd_wr;
  logic [AW-1:0] cfg_addr;
  logic [CW-1:0] cfg_wdata, cfg_rdata;
  logic          cfg_rvalid;
  logic [4*CW-1:0] counter_o;
  logic [3:0]    done_o, tc_pulse_o;
  logic          irq_o;

  logic          b_cfg_enable, b_cfg_rd_wr;
  logic [AW-1:0] b_cfg_addr;
  logic [CW-1:0] b_cfg_wdata, b_cfg_rdata;
  logic          b_cfg_rvalid;
  logic [3*CW-1:0] b_counter_o;
  logic [2:0]    b_done_o, b_tc_pulse_o;
  logic          b_irq_o;

  pcounter_mc #(.NUM_CH(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_rd_wr(cfg_rd_wr),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .cfg_rvalid(cfg_rvalid), .counter_o(counter_o), .done_o(done_o),
    .tc_pulse_o(tc_pulse_o), .irq_o(irq_o)
  );

  pcounter_mc #(.NUM_CH(3), .CNT_W(CW)) dut3 (
    .clk(clk), .rst(rst), .cfg_enable(b_cfg_enable), .cfg_rd_wr(b_cfg_rd_wr),
    .cfg_addr(b_cfg_addr), .cfg_wdata(b_cfg_wdata), .cfg_rdata(b_cfg_rdata),
    .cfg_rvalid(b_cfg_rvalid), .counter_o(b_counter_o), .done_o(b_done_o),
    .tc_pulse_o(b_tc_pulse_o), .irq_o(b_irq_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] expq[$];
  logic [CW-1:0] expq3[$];

  typedef struct {
    logic [AW-1:0] addr;
    bit            rd;
    logic [CW-1:0] wdata;
    logic [CW-1:0] exp;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] cnt(input int k);
    return counter_o[k*CW +: CW];
  endfunction

  // One access, driven after a falling edge and dropped after the next one.
  task automatic acc(input bit b, input logic [AW-1:0] a, input bit rdw,
                     input logic [CW-1:0] wd, input logic [CW-1:0] exp);
    if (!b) begin
      cfg_enable = 1'b1; cfg_rd_wr = rdw; cfg_addr = a; cfg_wdata = wd;
      if (rdw) expq.push_back(exp);
    end else begin
      b_cfg_enable = 1'b1; b_cfg_rd_wr = rdw; b_cfg_addr = a; b_cfg_wdata = wd;
      if (rdw) expq3.push_back(exp);
    end
    @(negedge clk);
    cfg_enable   = 1'b0;
    b_cfg_enable = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cfg_rvalid !== 1'b0) begin
      if (expq.size() == 0) chk("rvalid_unexpected", cfg_rvalid, 0);
      else                  chk("rdata", cfg_rdata, expq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (b_cfg_rvalid !== 1'b0) begin
      if (expq3.size() == 0) chk("rvalid3_unexpected", b_cfg_rvalid, 0);
      else                   chk("rdata3", b_cfg_rdata, expq3.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{4'h5,  1'b0, 10'h155, 10'h000};
    tbl[1] = '{4'h5,  1'b1, 10'h000, 10'h155};
    tbl[2] = '{4'h4,  1'b0, 10'h3F6, 10'h000};
    tbl[3] = '{4'h4,  1'b1, 10'h000, 10'h006};
    tbl[4] = '{4'h7,  1'b1, 10'h000, 10'h155};
    tbl[5] = '{4'hA,  1'b0, 10'h2AA, 10'h000};
    tbl[6] = '{4'hA,  1'b1, 10'h000, 10'h2AA};
    tbl[7] = '{4'h8,  1'b1, 10'h000, 10'h000};
    tbl[8] = '{4'h4,  1'b0, 10'h000, 10'h000};
    tbl[9] = '{4'h7,  1'b0, 10'h000, 10'h000};

    cfg_enable = 0; cfg_rd_wr = 0; cfg_addr = '0; cfg_wdata = '0;
    b_cfg_enable = 0; b_cfg_rd_wr = 0; b_cfg_addr = '0; b_cfg_wdata = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_counter", counter_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_tc", tc_pulse_o, 0);
    chk("rst_irq", irq_o, 0);
    chk("rst_rdata", cfg_rdata, 0);
    chk("rst_rvalid", cfg_rvalid, 0);
    acc(0, 4'h3, 1, 0, 10'h000);

    for (int i = 0; i < 10; i++)
      acc(0, tbl[i].addr, tbl[i].rd, tbl[i].wdata, tbl[i].exp);
    chk("tbl_cnt1", cnt(1), 0);
    chk("tbl_cnt2", cnt(2), 0);

    // ch0 up/wrap: LOAD=1, LIMIT=5
    acc(0, 4'h1, 0, 10'd1, 0);
    acc(0, 4'h2, 0, 10'd5, 0);
    acc(0, 4'h0, 0, 10'h10, 0);
    chk("up_loaded", cnt(0), 1);
    acc(0, 4'h0, 0, 10'h1, 0);
    for (int i = 0; i < 11; i++) begin
      chk("up_count", cnt(0), (i % 5) + 1);
      chk("up_tc", tc_pulse_o[0], ((i % 5) + 1) == 5);
      @(negedge clk);
    end
    chk("up_done", done_o[0], 1);
    chk("up_irq", irq_o, 1);

    // W1C in the terminal cycle, then W1C with no terminal
    repeat (3) @(negedge clk);
    chk("w1c_pre_cnt", cnt(0), 5);
    chk("w1c_pre_tc", tc_pulse_o[0], 1);
    acc(0, 4'h0, 0, 10'h9, 0);
    chk("w1c_collide_done", done_o[0], 1);
    chk("w1c_collide_cnt", cnt(0), 1);
    acc(0, 4'h0, 0, 10'h8, 0);
    chk("w1c_done", done_o, 0);
    chk("w1c_irq", irq_o, 0);
    chk("w1c_cnt", cnt(0), 2);
    @(negedge clk);
    chk("disabled_hold", cnt(0), 2);

    // ch3 down/one-shot: LOAD=3, LIMIT=0
    acc(0, 4'hD, 0, 10'd3, 0);
    acc(0, 4'hC, 0, 10'h10, 0);
    acc(0, 4'hE, 0, 10'd0, 0);
    acc(0, 4'hC, 0, 10'h7, 0);
    for (int i = 0; i < 6; i++) begin
      chk("dn_count", cnt(3), (i < 3) ? 3 - i : 0);
      chk("dn_tc", tc_pulse_o[3], i == 3);
      @(negedge clk);
    end
    acc(0, 4'hC, 1, 0, 10'h00E);
    chk("dn_done", done_o[3], 1);
    chk("dn_irq", irq_o, 1);

    // CTRL en write in a one-shot terminal cycle keeps en set
    acc(0, 4'hC, 0, 10'h7, 0);
    chk("os_tc", tc_pulse_o[3], 1);
    acc(0, 4'hC, 0, 10'h7, 0);
    acc(0, 4'hC, 1, 0, 10'h00F);
    acc(0, 4'hC, 1, 0, 10'h00E);

    // ch1 force while counting
    acc(0, 4'h6, 0, 10'h100, 0);
    acc(0, 4'h4, 0, 10'h1, 0);
    chk("frc_start", cnt(1), 0);
    @(negedge clk);
    chk("frc_run", cnt(1), 1);
    acc(0, 4'h7, 0, 10'h3FF, 0);
    chk("frc_forced", cnt(1), 10'h3FF);
    @(negedge clk);
    chk("frc_wrap", cnt(1), 0);
    acc(0, 4'h4, 0, 10'h0, 0);

    // 3-channel instance: channel 3 is out of range
    acc(1, 4'hD, 0, 10'h055, 0);
    acc(1, 4'hF, 0, 10'h077, 0);
    acc(1, 4'hF, 1, 0, 10'h000);
    acc(1, 4'hD, 1, 0, 10'h000);
    chk("oor_counters", b_counter_o, 0);
    acc(1, 4'h9, 0, 10'h044, 0);
    acc(1, 4'h9, 1, 0, 10'h044);
    acc(1, 4'h3, 0, 10'h012, 0);
    chk("b_cnt0_forced", b_counter_o[CW-1:0], 10'h012);

    // reset while ch2 is counting
    acc(0, 4'h8, 0, 10'h1, 0);
    repeat (7) @(negedge clk);
    chk("mid_cnt2", cnt(2), 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_counter", counter_o, 0);
    chk("mid_done", done_o, 0);
    chk("mid_irq", irq_o, 0);
    chk("mid_tc", tc_pulse_o, 0);
    chk("mid_rvalid", cfg_rvalid, 0);
    chk("mid_b_counter", b_counter_o, 0);
    repeat (5) @(negedge clk);
    chk("mid_idle", counter_o, 0);
    acc(0, 4'h8, 1, 0, 10'h000);
    acc(0, 4'hA, 1, 0, 10'h000);

    @(negedge clk);
    chk("sb_empty", expq.size() + expq3.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
